// File: rtl/haze_pkg.sv
// Shared types and constants for the haze-removal pipeline controllers.
package haze_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_LATCH = 3'd4
  } state_e;

endpackage

// File: rtl/alight_ctrl_lat_cnt.sv
// Loadable down-counter with zero flag, used to wait out pipeline latency.
module alight_ctrl_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alight_ctrl.sv
// Frame sequencer for the R/G/B atmospheric-light estimators.
// state | meaning
// IDLE  | waiting for start; latched A held
// CLEAR | one-cycle clear of estimator maxima, window count reset
// RUN   | accepting windows, est_enable follows each accept
// DRAIN | waiting EST_LAT cycles for estimator outputs to settle
// LATCH | capture final A values, pulse done
module alight_ctrl import haze_pkg::*; #(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int EST_LAT = 2,
  parameter int CW      = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             win_valid,
  output logic             win_ready,
  output logic             est_enable,
  output logic             est_clear,
  input  logic [PIX_W-1:0] a_r_in,
  input  logic [PIX_W-1:0] a_g_in,
  input  logic [PIX_W-1:0] a_b_in,
  output logic [PIX_W-1:0] a_r,
  output logic [PIX_W-1:0] a_g,
  output logic [PIX_W-1:0] a_b,
  output logic             a_valid,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    win_cnt
);

  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);
  localparam logic [CW-1:0] NWIN_M1 = CW'(NWIN - 1);
  localparam int LW = (EST_LAT > 1) ? $clog2(EST_LAT) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(EST_LAT - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    win_cnt_q, win_cnt_d;
  logic             a_valid_q, a_valid_d;
  logic [PIX_W-1:0] a_r_q, a_g_q, a_b_q;
  logic             latch_en;
  logic             lat_load, lat_dec, lat_zero;

  alight_ctrl_lat_cnt #(.W(LW)) u_lat_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (lat_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (lat_dec),
    .zero_o     (lat_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      win_cnt_q <= '0;
      a_valid_q <= 1'b0;
      a_r_q     <= '0;
      a_g_q     <= '0;
      a_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      a_valid_q <= a_valid_d;
      if (latch_en) begin
        a_r_q <= a_r_in;
        a_g_q <= a_g_in;
        a_b_q <= a_b_in;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    a_valid_d  = a_valid_q;
    win_ready  = 1'b0;
    est_enable = 1'b0;
    est_clear  = 1'b0;
    done       = 1'b0;
    latch_en   = 1'b0;
    lat_load   = 1'b0;
    lat_dec    = 1'b0;
    // abort overrides every active state; handshake outputs stay low that cycle
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      a_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d   = S_CLEAR;
            a_valid_d = 1'b0;
          end
        end
        S_CLEAR: begin
          est_clear = 1'b1;
          win_cnt_d = '0;
          state_d   = S_RUN;
        end
        S_RUN: begin
          win_ready = 1'b1;
          if (win_valid) begin
            est_enable = 1'b1;
            win_cnt_d  = win_cnt_q + CW'(1);
            if (win_cnt_q == NWIN_M1) begin
              state_d  = S_DRAIN;
              lat_load = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (lat_zero) state_d = S_LATCH;
          else          lat_dec = 1'b1;
        end
        S_LATCH: begin
          done      = 1'b1;
          latch_en  = 1'b1;
          a_valid_d = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign a_valid = a_valid_q;
  assign a_r     = a_r_q;
  assign a_g     = a_g_q;
  assign a_b     = a_b_q;
  assign win_cnt = win_cnt_q;

endmodule

// File: tb/tb_alight_ctrl.sv
// Directed bench for alight_ctrl with a 5x4 frame (6 windows) and EST_LAT=2.
module tb_alight_ctrl;

  localparam int CW = 20;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, win_valid = 1'b0;
  logic          win_ready, est_enable, est_clear;
  logic [7:0]    a_r_in = 8'd0, a_g_in = 8'd0, a_b_in = 8'd0;
  logic [7:0]    a_r, a_g, a_b;
  logic          a_valid, busy, done;
  logic [CW-1:0] win_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  alight_ctrl #(.IMG_W(5), .IMG_H(4), .EST_LAT(2), .CW(CW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .win_valid(win_valid), .win_ready(win_ready), .est_enable(est_enable),
    .est_clear(est_clear), .a_r_in(a_r_in), .a_g_in(a_g_in), .a_b_in(a_b_in),
    .a_r(a_r), .a_g(a_g), .a_b(a_b), .a_valid(a_valid), .busy(busy),
    .done(done), .win_cnt(win_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one full frame with win_valid held high; returns done pulses seen.
  task automatic run_frame(output int dn);
    dn = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    win_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (done) dn++;
      tick();
    end
    win_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    nchk++;
    if ({win_ready, est_enable, est_clear, busy, done, a_valid} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctl: got %b want 000000", {win_ready, est_enable, est_clear, busy, done, a_valid});
    end
    nchk++;
    if ({a_r, a_g, a_b} !== 24'd0 || win_cnt !== '0) begin
      nerr++; $display("FAIL reset_data: got a=%0d/%0d/%0d cnt=%0d want 0", a_r, a_g, a_b, win_cnt);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    int en, cyc;
    a_r_in = 8'd205; a_g_in = 8'd207; a_b_in = 8'd207;
    start = 1'b1;
    #1;
    nchk++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL ff_idle_busy: got %b want 0", busy); end
    tick();
    start = 1'b0;
    #1;
    nchk++;
    if (est_clear !== 1'b1 || busy !== 1'b1 || win_ready !== 1'b0) begin
      nerr++; $display("FAIL ff_clear: got clr=%b busy=%b rdy=%b want 1 1 0", est_clear, busy, win_ready);
    end
    tick();
    win_valid = 1'b1;
    en = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (est_enable) en++;
      nchk++;
      if (win_ready !== 1'b1) begin nerr++; $display("FAIL ff_ready_%0d: got %b want 1", i, win_ready); end
      tick();
    end
    #1;
    nchk++;
    if (en !== 6) begin nerr++; $display("FAIL ff_enables: got %0d want 6", en); end
    nchk++;
    if (win_ready !== 1'b0 || est_enable !== 1'b0 || win_cnt !== 20'd6) begin
      nerr++; $display("FAIL ff_drain: got rdy=%b en=%b cnt=%0d want 0 0 6", win_ready, est_enable, win_cnt);
    end
    cyc = 0;
    while (!done && cyc < 10) begin tick(); #1; cyc++; end
    nchk++;
    if (cyc !== 2) begin nerr++; $display("FAIL ff_done_lat: got %0d want 2", cyc); end
    tick();
    win_valid = 1'b0;
    #1;
    nchk++;
    if (a_r !== 8'd205 || a_g !== 8'd207 || a_b !== 8'd207 || a_valid !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL ff_latched: got a=%0d/%0d/%0d v=%b busy=%b done=%b want 205/207/207 1 0 0",
                       a_r, a_g, a_b, a_valid, busy, done);
    end
  endtask

  task automatic test_stall();
    int cyc;
    logic mis;
    a_r_in = 8'd10; a_g_in = 8'd20; a_b_in = 8'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    nchk++;
    if (a_valid !== 1'b0) begin nerr++; $display("FAIL st_valid_clr: got %b want 0", a_valid); end
    tick();
    cyc = 0;
    mis = 1'b0;
    while (win_cnt != 20'd6 && cyc < 30) begin
      win_valid = (cyc % 2 == 0);
      #1;
      if (est_enable !== win_valid) mis = 1'b1;
      tick();
      cyc++;
    end
    win_valid = 1'b0;
    nchk++;
    if (mis !== 1'b0) begin nerr++; $display("FAIL st_enable: got stray/missing enable want none"); end
    nchk++;
    if (cyc !== 11) begin nerr++; $display("FAIL st_cycles: got %0d want 11", cyc); end
    #1;
    cyc = 0;
    while (!done && cyc < 10) begin tick(); #1; cyc++; end
    nchk++;
    if (cyc !== 2) begin nerr++; $display("FAIL st_done_lat: got %0d want 2", cyc); end
    tick();
    #1;
    nchk++;
    if (a_r !== 8'd10 || a_g !== 8'd20 || a_b !== 8'd30 || a_valid !== 1'b1) begin
      nerr++; $display("FAIL st_latched: got %0d/%0d/%0d v=%b want 10/20/30 1", a_r, a_g, a_b, a_valid);
    end
  endtask

  task automatic test_abort();
    int dn;
    a_r_in = 8'd99; a_g_in = 8'd98; a_b_in = 8'd97;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    win_valid = 1'b1;
    tick(); tick(); tick();
    abort = 1'b1;
    #1;
    nchk++;
    if (win_ready !== 1'b0 || est_enable !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL ab_cycle: got rdy=%b en=%b busy=%b want 0 0 1", win_ready, est_enable, busy);
    end
    tick();
    abort = 1'b0;
    win_valid = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b0 || a_valid !== 1'b0 || win_cnt !== 20'd3) begin
      nerr++; $display("FAIL ab_idle: got busy=%b v=%b cnt=%0d want 0 0 3", busy, a_valid, win_cnt);
    end
    nchk++;
    if (a_r !== 8'd10 || a_g !== 8'd20 || a_b !== 8'd30) begin
      nerr++; $display("FAIL ab_retain: got %0d/%0d/%0d want 10/20/30", a_r, a_g, a_b);
    end
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dn++;
      tick(); #1;
    end
    nchk++;
    if (dn !== 0) begin nerr++; $display("FAIL ab_nodone: got %0d want 0", dn); end
    a_r_in = 8'd1; a_g_in = 8'd2; a_b_in = 8'd3;
    run_frame(dn);
    #1;
    nchk++;
    if (dn !== 1 || a_r !== 8'd1 || a_g !== 8'd2 || a_b !== 8'd3 || a_valid !== 1'b1) begin
      nerr++; $display("FAIL ab_restart: got dn=%0d a=%0d/%0d/%0d v=%b want 1 1/2/3 1", dn, a_r, a_g, a_b, a_valid);
    end
  endtask

  task automatic test_start_in_run();
    int dn;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    win_valid = 1'b1;
    tick(); tick();
    start = 1'b1;
    #1;
    nchk++;
    if (win_ready !== 1'b1 || win_cnt !== 20'd2) begin
      nerr++; $display("FAIL sr_run: got rdy=%b cnt=%0d want 1 2", win_ready, win_cnt);
    end
    tick();
    start = 1'b0;
    nchk++;
    if (win_cnt !== 20'd3) begin nerr++; $display("FAIL sr_cnt: got %0d want 3", win_cnt); end
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (done) dn++;
      tick();
    end
    win_valid = 1'b0;
    #1;
    nchk++;
    if (dn !== 1 || win_cnt !== 20'd6 || busy !== 1'b0) begin
      nerr++; $display("FAIL sr_single: got dn=%0d cnt=%0d busy=%b want 1 6 0", dn, win_cnt, busy);
    end
  endtask

  task automatic test_reset_in_drain();
    start = 1'b1;
    tick();
    start = 1'b0;
    win_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    win_valid = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b1 || win_cnt !== 20'd6 || win_ready !== 1'b0) begin
      nerr++; $display("FAIL rd_in_drain: got busy=%b cnt=%0d rdy=%b want 1 6 0", busy, win_cnt, win_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    nchk++;
    if ({busy, a_valid, done, win_ready, est_enable, est_clear} !== 6'b0 || win_cnt !== '0 || {a_r, a_g, a_b} !== 24'd0) begin
      nerr++; $display("FAIL rd_async: got ctl=%b cnt=%0d a=%0d/%0d/%0d want 0",
                       {busy, a_valid, done, win_ready, est_enable, est_clear}, win_cnt, a_r, a_g, a_b);
    end
    #2;
    reset_n = 1'b1;
    tick();
    #1;
    nchk++;
    if (busy !== 1'b0 || win_ready !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL rd_release: got busy=%b rdy=%b done=%b want 0 0 0", busy, win_ready, done);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    #1;
    nchk++;
    if (est_clear !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL sa_same: got clr=%b busy=%b want 0 0", est_clear, busy);
    end
    tick();
    start = 1'b0;
    abort = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b0 || est_clear !== 1'b0 || win_ready !== 1'b0) begin
      nerr++; $display("FAIL sa_after: got busy=%b clr=%b rdy=%b want 0 0 0", busy, est_clear, win_ready);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_abort();
    test_start_in_run();
    test_reset_in_drain();
    test_start_abort_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
